// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the PISO serializer: FSM state encoding and
// the bit-counter width function.
package piso_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Counter width needed to count 0..width-1; never narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter for the serializer: increments on each enabled bit, clears
// synchronously, and flags the terminal count (WIDTH-1).
module piso_bit_counter
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic clr_i,
   output logic tc_o
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer feeding a right-shift register LSB-first.
// Optional macro PISO_BACK_TO_BACK_EN allows reload on the last bit (no idle bubble).
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             stall,
   output logic             serial_out,
   output logic             serial_en,
   output logic             word_done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             word_done_q, word_done_d;

   logic shifting;
   logic bit_en;
   logic tc;
   logic last_bit;
   logic accept;

   assign shifting = (state_q == SHIFT);
   assign bit_en   = shifting && !stall;
   assign last_bit = bit_en && tc;

`ifdef PISO_BACK_TO_BACK_EN
   assign in_ready = !shifting || last_bit;
`else
   assign in_ready = !shifting;
`endif

   assign accept = in_valid && in_ready;

   piso_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk   (clk),
      .reset (reset),
      .en_i  (bit_en),
      .clr_i (accept || last_bit),
      .tc_o  (tc)
   );

   // A load wins over the final shift so a back-to-back word replaces the drained one.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      word_done_d = last_bit;
      if (accept) begin
         shreg_d = in_data;
         state_d = SHIFT;
      end else if (bit_en) begin
         shreg_d = shreg_q >> 1;
         if (last_bit) begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         word_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         word_done_q <= word_done_d;
      end
   end

   assign serial_en  = bit_en;
   assign serial_out = shifting && shreg_q[0];
   assign word_done  = word_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: table-driven frames, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_piso_serializer;

   localparam int W = 8;
`ifdef PISO_BACK_TO_BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif
   localparam int GAP = B2B ? W : W + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         stall;
   logic         serial_out;
   logic         serial_en;
   logic         word_done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   piso_serializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .stall      (stall),
      .serial_out (serial_out),
      .serial_en  (serial_en),
      .word_done  (word_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: words accepted but not fully emitted, bits emitted from the head word.
   logic [W-1:0] acc_q[$];
   int           cur_bits  = 0;
   bit           done_pend = 1'b0;
   logic [W-1:0] done_word = '0;
   logic [W-1:0] ds        = '0;
   int           done_log[$];
   logic [W-1:0] done_ds[$];

   always @(negedge clk) begin
      logic         pend, e_en, e_rdy, e_out, e_done;
      logic [W-1:0] fw;
      if (!reset) begin
         acc_q.delete();
         cur_bits  = 0;
         done_pend = 1'b0;
      end else begin
         pend   = (acc_q.size() > 0);
         fw     = pend ? acc_q[0] : '0;
         e_en   = pend && !stall;
         e_rdy  = !pend || (B2B && pend && cur_bits == W - 1 && !stall);
         e_out  = pend ? fw[cur_bits] : 1'b0;
         e_done = done_pend;
         chk("serial_en", 32'(serial_en), 32'(e_en));
         chk("serial_out", 32'(serial_out), 32'(e_out));
         chk("in_ready", 32'(in_ready), 32'(e_rdy));
         chk("word_done", 32'(word_done), 32'(e_done));
         if (e_done) chk("downstream_word", 32'(ds), 32'(done_word));
         if (word_done) begin
            done_log.push_back(cyc);
            done_ds.push_back(ds);
         end
         if (serial_en) ds = {serial_out, ds[W-1:1]};
         done_pend = 1'b0;
         if (e_en) begin
            cur_bits++;
            if (cur_bits == W) begin
               done_word = acc_q.pop_front();
               cur_bits  = 0;
               done_pend = 1'b1;
            end
         end
         if (in_valid && e_rdy) acc_q.push_back(in_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] w, input bit keep_valid, output int acc);
      bit got = 1'b0;
      acc      = -1;
      in_data  = w;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         #1;
         if (in_ready) begin
            acc = cyc;
            got = 1'b1;
         end
      end
      if (!got) chk("accept_timeout", 32'(0), 32'(1));
      tick();
      if (!keep_valid) in_valid = 1'b0;
   endtask

   task automatic wait_done(input int n);
      for (int i = 0; i < 200 && done_log.size() < n; i++) tick();
      if (done_log.size() < n) chk("done_timeout", 32'(done_log.size()), 32'(n));
   endtask

   typedef struct {
      logic [W-1:0] data;
      int           stall_after;
      int           stall_len;
      int           exp_lat;
      logic [W-1:0] exp_word;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int a0, a1, lat;
      vecs[0] = '{8'hA5, 0, 0, 9,  8'hA5};
      vecs[1] = '{8'h3C, 2, 3, 12, 8'h3C};
      vecs[2] = '{8'h00, 0, 0, 9,  8'h00};
      vecs[3] = '{8'hFF, 0, 0, 9,  8'hFF};
      vecs[4] = '{8'h81, 7, 2, 11, 8'h81};
      vecs[5] = '{8'h5A, 0, 2, 11, 8'h5A};

      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      stall    = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_serial_en", 32'(serial_en), 32'(0));
      chk("rst_serial_out", 32'(serial_out), 32'(0));
      chk("rst_word_done", 32'(word_done), 32'(0));
      repeat (2) tick();
      reset = 1'b1;
      stall = 1'b0;
      tick();

      for (int v = 0; v < 6; v++) begin
         done_log.delete();
         done_ds.delete();
         send_word(vecs[v].data, 1'b0, a0);
         if (vecs[v].stall_len > 0) begin
            repeat (vecs[v].stall_after) tick();
            stall = 1'b1;
            repeat (vecs[v].stall_len) tick();
            stall = 1'b0;
         end
         wait_done(1);
         if (done_log.size() >= 1) begin
            chk("vec_latency", 32'(done_log[0] - a0), 32'(vecs[v].exp_lat));
            chk("vec_word", 32'(done_ds[0]), 32'(vecs[v].exp_word));
         end
         repeat (2) tick();
      end

      // F0 frame with 11 held valid behind it.
      done_log.delete();
      done_ds.delete();
      send_word(8'hF0, 1'b1, a0);
      send_word(8'h11, 1'b0, a1);
      chk("b2b_accept_gap", 32'(a1 - a0), 32'(GAP));
      wait_done(2);
      if (done_log.size() >= 2) begin
         chk("b2b_done0", 32'(done_log[0] - a0), 32'(W + 1));
         chk("b2b_done1", 32'(done_log[1] - a0), 32'(GAP + W + 1));
         chk("b2b_word0", 32'(done_ds[0]), 32'(8'hF0));
         chk("b2b_word1", 32'(done_ds[1]), 32'(8'h11));
      end
      repeat (3) tick();

      // Boundary words back-to-back.
      done_log.delete();
      done_ds.delete();
      send_word(8'h00, 1'b1, a0);
      send_word(8'hFF, 1'b0, a1);
      wait_done(2);
      if (done_log.size() >= 2) begin
         chk("bound_done_gap", 32'(done_log[1] - done_log[0]), 32'(GAP));
         chk("bound_word0", 32'(done_ds[0]), 32'(8'h00));
         chk("bound_word1", 32'(done_ds[1]), 32'(8'hFF));
      end
      tick();
      chk("bound_pulse_width", 32'(word_done), 32'(0));
      repeat (3) tick();

      // Asynchronous reset during bit 4 of FF.
      done_log.delete();
      done_ds.delete();
      send_word(8'hFF, 1'b0, a0);
      repeat (3) tick();
      #2;
      reset = 1'b0;
      #1;
      chk("arst_in_ready", 32'(in_ready), 32'(1));
      chk("arst_serial_en", 32'(serial_en), 32'(0));
      chk("arst_serial_out", 32'(serial_out), 32'(0));
      chk("arst_word_done", 32'(word_done), 32'(0));
      repeat (2) tick();
      reset = 1'b1;
      repeat (12) tick();
      chk("arst_no_done", 32'(done_log.size()), 32'(0));
      done_log.delete();
      done_ds.delete();
      send_word(8'h55, 1'b0, a0);
      wait_done(1);
      if (done_log.size() >= 1) begin
         lat = done_log[0] - a0;
         chk("arst_next_latency", 32'(lat), 32'(W + 1));
         chk("arst_next_word", 32'(done_ds[0]), 32'(8'h55));
      end
      repeat (2) tick();

      // Randomized traffic, checked cycle by cycle by the model.
      for (int i = 0; i < 400; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = W'($urandom);
         stall    = ($urandom_range(0, 4) == 0);
         tick();
      end
      in_valid = 1'b0;
      stall    = 1'b0;
      repeat (20) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out serializer that sits directly upstream of the right-shift (serial-in parallel-out) register. It accepts a WIDTH-bit word over a valid/ready handshake and emits it LSB-first as a serial bit with a per-bit enable. Its outputs drive the shift register's serial input and enable, so after WIDTH enabled bits the downstream register holds the original word unchanged.

Parameters:
WIDTH, 8, word width in bits and number of serial bits per word; legal range WIDTH >= 2; must equal the downstream DEPTH.
CNT_W, $clog2(WIDTH), bit-counter width; localparam, not overridable.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_data  input  WIDTH  parallel word to serialize
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
stall  input  1  downstream pause; freezes shifting while high
serial_out  output  1  current serial bit (LSB-first); drives downstream in
serial_en  output  1  serial_out is valid this cycle; drives downstream enable
word_done  output  1  one-cycle pulse, the cycle after the last bit of a word was enabled

Behaviour:
- Reset (reset==0, async): state=IDLE, shreg=0, cnt=0, word_done=0. This gives in_ready=1, serial_en=0, serial_out=0.
- A reset asserted mid-frame discards the word; no word_done is produced for it.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1, serial_en=0.
  - On in_valid&&in_ready at a clock edge: shreg<=in_data, cnt<=0, state<=SHIFT.
  - stall is ignored in IDLE.
- SHIFT:
  - serial_out=shreg[0]; serial_en=!stall, combinational from state and stall.
  - On each edge with serial_en=1: shreg<=shreg>>1 (zero-fill), cnt<=cnt+1.
  - On each edge with stall=1: shreg and cnt hold; serial_out stays stable.
  - Last bit: cnt==WIDTH-1 && serial_en. At that edge cnt<=0, word_done<=1 for exactly the next cycle, and state<=IDLE unless reloaded (see Optional Feature).
- Timing: first serial_en is in the cycle after acceptance. Latency from acceptance to word_done is WIDTH+1 cycles with no stalls, plus one cycle per stalled SHIFT cycle. word_done coincides with the downstream register first holding the complete word.
- Handshake: the word transfers only when in_valid&&in_ready at an edge. While in_ready=0, the source holds in_data/in_valid stable and nothing is consumed. in_valid may drop without a transfer.
- Boundary: all-zero and all-ones words are serialized normally. serial_out is 0 in IDLE.

Optional Feature:
Macro PISO_BACK_TO_BACK_EN.
- Defined: in_ready is also 1 in SHIFT when cnt==WIDTH-1 && !stall. An acceptance at that edge loads the new word with cnt<=0 and state stays SHIFT. word_done still pulses for the finished word. Throughput is one word per WIDTH cycles with no idle bubble.
- Undefined: in_ready=1 only in IDLE. Throughput is one word per WIDTH+1 cycles.

Decomposition:
- Package piso_serializer_pkg holds the state encoding (IDLE=1'b0, SHIFT=1'b1) as a typedef/localparams. It also holds a helper function for CNT_W.
- One sub-module, piso_bit_counter: CNT_W-bit counter with enable, synchronous clear and terminal-count flag (cnt==WIDTH-1). Same async active-low reset.
- The top level holds the FSM, shreg and word_done.

Test Plan:
- WIDTH=8, reset released, in_data=8'hA5 accepted at cycle 0 -> serial_en high cycles 1-8 with serial_out 1,0,1,0,0,1,0,1; word_done pulse at cycle 9; downstream DEPTH=8 register reads 8'hA5; in_ready back to 1 at cycle 9.
- Load 8'h3C, stall high for 3 cycles after bit 2 -> serial_en low and serial_out held for those 3 cycles; word_done at cycle 12; downstream holds 8'h3C.
- in_valid held high with 8'h11 during an 8'hF0 frame (macro off) -> 8'h11 is not accepted until cycle 9. Two words occupy cycles 1-8 and 10-17; word_done pulses at 9 and 18.
- Macro on: continuous words 8'h01, 8'h80 -> second accepted at cycle 8; serial bits contiguous cycles 1-16; word_done pulses at cycles 9 and 17.
- reset asserted asynchronously mid-cycle during bit 4 of 8'hFF -> outputs go to reset values immediately, no word_done; the next word 8'h55 serializes correctly.
- Boundary words 8'h00 and 8'hFF back-to-back -> correct bit streams, each word_done exactly one cycle wide.
